// File: rtl/serpent_pkg.sv
// Shared Serpent constants: S-box tables, round counts, FSM states and the
// IP-domain linear transform used by the iterative round engine.
package serpent_pkg;

    localparam int ROUND_COUNT  = 32;
    localparam int SUBKEY_COUNT = 33;

    localparam int LT_ROT_X0_A = 13;
    localparam int LT_ROT_X2_A = 3;
    localparam int LT_SHL_X0   = 3;
    localparam int LT_ROT_X1   = 1;
    localparam int LT_ROT_X3   = 7;
    localparam int LT_SHL_X1   = 7;
    localparam int LT_ROT_X0_B = 5;
    localparam int LT_ROT_X2_B = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Entry v of box n lives in SBOX_TABLE[n][4v+3:4v].
    localparam logic [63:0] SBOX_TABLE [8] = '{
        64'hC90724DEB56A1F83,
        64'h43D68EB1A50972CF,
        64'h25B04E1DFAC39768,
        64'hE57A421D369C8BF0,
        64'hD7E9A4526B0C38F1,
        64'h176D8E30C9A4B25F,
        64'h0A3DF19EB6485C27,
        64'h6539AC47B28E0FD1
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] fp128(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 4; j++) begin
                y[32*j + k] = x[4*k + j];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] ip128(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 4; j++) begin
                y[4*k + j] = x[32*j + k];
            end
        end
        return y;
    endfunction

    // Linear transform applied to an IP-domain state; pure wiring and XORs.
    function automatic logic [127:0] lt_ip(input logic [127:0] b);
        logic [127:0] w;
        logic [31:0]  x0, x1, x2, x3;
        w  = fp128(b);
        x0 = w[31:0];
        x1 = w[63:32];
        x2 = w[95:64];
        x3 = w[127:96];
        x0 = rotl32(x0, LT_ROT_X0_A);
        x2 = rotl32(x2, LT_ROT_X2_A);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << LT_SHL_X0);
        x1 = rotl32(x1, LT_ROT_X1);
        x3 = rotl32(x3, LT_ROT_X3);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << LT_SHL_X1);
        x0 = rotl32(x0, LT_ROT_X0_B);
        x2 = rotl32(x2, LT_ROT_X2_B);
        return ip128({x3, x2, x1, x0});
    endfunction

endpackage

// File: rtl/serpent_sbox_layer.sv
// One Serpent substitution layer: the selected 4-bit S-box applied to all
// 32 nibbles of an IP-domain state in parallel.
module serpent_sbox_layer
    import serpent_pkg::*;
(
    input  logic [127:0] data_i,
    input  logic [2:0]   sel_i,
    output logic [127:0] data_o
);

    logic [63:0] table_s;

    // Select the active box table.
    always_comb begin
        table_s = SBOX_TABLE[sel_i];
    end

    // Nibble-wise lookup; the nibble value scaled by four addresses its entry.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < 32; k++) begin
            data_o[4*k +: 4] = table_s[{data_i[4*k +: 4], 2'b00} +: 4];
        end
    end

endmodule

// File: rtl/serpent_round_engine.sv
// Iterative Serpent encryption core, one round per clock in the IP domain;
// subkeys are fetched combinationally by index.
module serpent_round_engine
    import serpent_pkg::*;
#(
    parameter int ROUNDS = ROUND_COUNT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic [5:0]   o_key_idx,
    input  logic [127:0] i_subkey,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [5:0] FINAL_KEY  = 6'(ROUNDS);

    state_e       state_q, state_d;
    logic [5:0]   round_q, round_d;
    logic [127:0] block_q, block_d;
    logic [127:0] sbox_in_s, sbox_out_s, lt_out_s;

    assign sbox_in_s = block_q ^ i_subkey;

    serpent_sbox_layer u_sbox (
        .data_i (sbox_in_s),
        .sel_i  (round_q[2:0]),
        .data_o (sbox_out_s)
    );

    assign lt_out_s = lt_ip(sbox_out_s);

    // State, round counter and block registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            round_q <= 6'd0;
            block_q <= 128'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            block_q <= block_d;
        end
    end

    // Next-state and datapath update; the last round skips the linear transform.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        block_d = block_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = ROUND;
                    round_d = 6'd0;
                    block_d = i_data;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                round_d = round_q + 6'd1;
                if (round_q == LAST_ROUND) begin
                    block_d = sbox_out_s;
                    state_d = FINAL;
                end else begin
                    block_d = lt_out_s;
                end
            end
            FINAL: begin
                block_d = block_q ^ i_subkey;
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b1;
        o_key_idx = 6'd0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
            end
            ROUND: begin
                o_key_idx = round_q;
            end
            FINAL: begin
                o_key_idx = FINAL_KEY;
            end
            DONE: begin
                o_valid = 1'b1;
            end
            default: begin
                o_busy = 1'b1;
            end
        endcase
    end

    assign o_data = block_q;

endmodule

// File: tb/tb_serpent_round_engine.sv
// Self-checking bench for serpent_round_engine against a bitslice-domain
// Serpent reference model with randomized data and subkeys.
module tb_serpent_round_engine;

    logic         clk;
    logic         rst;
    logic         valid_in_s;
    logic         ready_o_s;
    logic [127:0] data_in_s;
    logic [5:0]   key_idx_s;
    logic [127:0] subkey_s;
    logic         valid_o_s;
    logic         ready_in_s;
    logic [127:0] data_o_s;
    logic         busy_s;

    logic [127:0] keys [0:32];
    int n_checks = 0;
    int n_errors = 0;

    int unsigned sbox_ref [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    serpent_round_engine #(.ROUNDS(32)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid_in_s),
        .o_ready   (ready_o_s),
        .i_data    (data_in_s),
        .o_key_idx (key_idx_s),
        .i_subkey  (subkey_s),
        .o_valid   (valid_o_s),
        .i_ready   (ready_in_s),
        .o_data    (data_o_s),
        .o_busy    (busy_s)
    );

    // Combinational key store indexed by the engine.
    assign subkey_s = (key_idx_s <= 6'd32) ? keys[key_idx_s] : 128'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Bitslice view: word j bit k is bit j of nibble k.
    function automatic logic [3:0][31:0] to_words(input logic [127:0] v);
        logic [3:0][31:0] w;
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 4; j++)
                w[j][k] = v[4*k + j];
        return w;
    endfunction

    function automatic logic [127:0] from_words(input logic [3:0][31:0] w);
        logic [127:0] v;
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 4; j++)
                v[4*k + j] = w[j][k];
        return v;
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference Serpent state after the given number of clock steps past acceptance.
    function automatic logic [127:0] model_state(input logic [127:0] pt, input int steps);
        logic [3:0][31:0] w;
        logic [31:0] a, b, c, d;
        int unsigned col, sub;
        w = to_words(pt);
        for (int r = 0; r < 32 && r < steps; r++) begin
            w = w ^ to_words(keys[r]);
            for (int k = 0; k < 32; k++) begin
                col = {28'd0, w[3][k], w[2][k], w[1][k], w[0][k]};
                sub = sbox_ref[r % 8][col];
                for (int j = 0; j < 4; j++) w[j][k] = sub[j];
            end
            if (r != 31) begin
                a = rol(w[0], 13);
                c = rol(w[2], 3);
                b = w[1] ^ a ^ c;
                d = w[3] ^ c ^ (a << 3);
                b = rol(b, 1);
                d = rol(d, 7);
                a = a ^ b ^ d;
                c = c ^ d ^ (b << 7);
                w[0] = rol(a, 5);
                w[1] = b;
                w[2] = rol(c, 22);
                w[3] = d;
            end
        end
        if (steps >= 33) w = w ^ to_words(keys[32]);
        return from_words(w);
    endfunction

    // One block through the engine, optional output stall with a competing i_valid.
    task automatic run_block(input logic [127:0] pt, input int stall, input string tag);
        logic [127:0] exp_ct, held;
        exp_ct = model_state(pt, 33);
        check_eq({tag, "_ready_idle"}, 128'(ready_o_s), 128'd1);
        valid_in_s = 1'b1;
        data_in_s  = pt;
        ready_in_s = (stall == 0);
        step();
        valid_in_s = 1'b0;
        check_eq({tag, "_ready_drop"}, 128'(ready_o_s), 128'd0);
        check_eq({tag, "_busy"}, 128'(busy_s), 128'd1);
        for (int c = 0; c <= 32; c++) begin
            check_eq({tag, "_key_idx"}, 128'(key_idx_s), 128'(c));
            check_eq({tag, "_valid_low"}, 128'(valid_o_s), 128'd0);
            if (c == 1) check_eq({tag, "_round0"}, data_o_s, model_state(pt, 1));
            if (c == 16) check_eq({tag, "_round15"}, data_o_s, model_state(pt, 16));
            step();
        end
        check_eq({tag, "_valid"}, 128'(valid_o_s), 128'd1);
        check_eq({tag, "_data"}, data_o_s, exp_ct);
        check_eq({tag, "_key_done"}, 128'(key_idx_s), 128'd0);
        held = data_o_s;
        if (stall > 0) begin
            valid_in_s = 1'b1;
            data_in_s  = rand128();
            for (int s = 0; s < stall; s++) begin
                step();
                check_eq({tag, "_stall_valid"}, 128'(valid_o_s), 128'd1);
                check_eq({tag, "_stall_data"}, data_o_s, held);
                check_eq({tag, "_stall_noacc"}, 128'(ready_o_s), 128'd0);
            end
            ready_in_s = 1'b1;
        end
        step();
        valid_in_s = 1'b0;
        check_eq({tag, "_back_idle"}, 128'(ready_o_s), 128'd1);
        check_eq({tag, "_valid_clr"}, 128'(valid_o_s), 128'd0);
    endtask

    initial begin
        logic [127:0] blk [4];
        logic [127:0] exp_q [$];
        int acc_cyc [$];
        int nacc, nout;
        logic acc, outv;
        logic [127:0] od;

        rst = 1'b1;
        valid_in_s = 1'b0;
        ready_in_s = 1'b1;
        data_in_s = 128'd0;
        for (int i = 0; i <= 32; i++) keys[i] = 128'd0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_valid", 128'(valid_o_s), 128'd0);
        check_eq("rst_ready", 128'(ready_o_s), 128'd1);
        check_eq("rst_busy", 128'(busy_s), 128'd0);
        check_eq("rst_key", 128'(key_idx_s), 128'd0);
        check_eq("rst_data", data_o_s, 128'd0);

        // Zero data/keys, plus an explicit look at the first round result.
        run_block(128'd0, 0, "zero");

        for (int i = 0; i <= 32; i++) keys[i] = rand128();
        run_block(rand128(), 0, "rand_a");
        run_block(rand128(), 0, "rand_b");
        run_block(rand128(), 10, "stall");
        run_block(rand128(), 0, "after_stall");

        // Reset during round 15 aborts the block.
        valid_in_s = 1'b1;
        data_in_s  = rand128();
        step();
        valid_in_s = 1'b0;
        for (int c = 0; c < 15; c++) step();
        check_eq("mid_key15", 128'(key_idx_s), 128'd15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_valid", 128'(valid_o_s), 128'd0);
        check_eq("mid_busy", 128'(busy_s), 128'd0);
        check_eq("mid_key", 128'(key_idx_s), 128'd0);
        check_eq("mid_data", data_o_s, 128'd0);
        run_block(rand128(), 0, "post_rst");

        // Back-to-back blocks with i_valid held high.
        for (int i = 0; i < 4; i++) blk[i] = rand128();
        nacc = 0;
        nout = 0;
        ready_in_s = 1'b1;
        valid_in_s = 1'b1;
        data_in_s  = blk[0];
        for (int cyc = 0; cyc < 400 && nout < 4; cyc++) begin
            acc  = ready_o_s && valid_in_s;
            outv = valid_o_s && ready_in_s;
            od   = data_o_s;
            step();
            if (acc) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(model_state(blk[nacc], 33));
                nacc++;
                if (nacc < 4) data_in_s = blk[nacc];
                else valid_in_s = 1'b0;
            end
            if (outv) begin
                check_eq("b2b_have_exp", 128'(exp_q.size() > 0), 128'd1);
                if (exp_q.size() > 0) check_eq("b2b_data", od, exp_q.pop_front());
                nout++;
            end
        end
        valid_in_s = 1'b0;
        check_eq("b2b_outputs", 128'(nout), 128'd4);
        check_eq("b2b_accepts", 128'(acc_cyc.size()), 128'd4);
        for (int i = 1; i < acc_cyc.size(); i++)
            check_eq("b2b_period", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd35);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
